// File: rtl/tetris_stats_pkg.sv
// ----------------------------------------------------------------------------
// tetris_stats_pkg
// Shared definitions for the game-statistics writer: BCD digit geometry,
// points table, FSM state encoding and small helper functions.
// ----------------------------------------------------------------------------
package tetris_stats_pkg;

    localparam int unsigned BCD_DIGIT_WIDTH = 4;
    localparam int unsigned NUMBER_LEN      = 6;
    localparam int unsigned DIGIT_IDX_W     = $clog2(NUMBER_LEN);

    // Digit 0 is the least significant digit.
    typedef logic [NUMBER_LEN-1:0][BCD_DIGIT_WIDTH-1:0] bcd_num_t;

    localparam bcd_num_t BCD_ZERO = 24'h000000;
    localparam bcd_num_t BCD_ONE  = 24'h000001;
    localparam bcd_num_t BCD_MAX  = 24'h999999;

    localparam bcd_num_t POINTS_1 = 24'h000100;
    localparam bcd_num_t POINTS_2 = 24'h000300;
    localparam bcd_num_t POINTS_3 = 24'h000500;
    localparam bcd_num_t POINTS_4 = 24'h000800;

    typedef enum logic [1:0] {
        StIdle,
        StAddLines,
        StAddScore,
        StCommit
    } state_e;

    function automatic logic is_legal(input logic [2:0] n);
        return (n >= 3'd1) && (n <= 3'd4);
    endfunction

    // Points added per level pass; illegal counts score nothing.
    function automatic bcd_num_t points_for(input logic [2:0] n);
        case (n)
            3'd1:    return POINTS_1;
            3'd2:    return POINTS_2;
            3'd3:    return POINTS_3;
            3'd4:    return POINTS_4;
            default: return BCD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/tetris_stats_if.sv
// ----------------------------------------------------------------------------
// tetris_stats_if
// Line-clear event handshake from the game FSM (master) to the statistics
// writer (slave).
//   lines_valid    master -> slave  event valid
//   lines_cleared  master -> slave  rows cleared by the event (1..4 legal)
//   lines_ready    slave  -> master writer idle, event accepted when valid
// ----------------------------------------------------------------------------
interface tetris_stats_if;

    logic       lines_valid;
    logic [2:0] lines_cleared;
    logic       lines_ready;

    modport master (
        output lines_valid,
        output lines_cleared,
        input  lines_ready
    );

    modport slave (
        input  lines_valid,
        input  lines_cleared,
        output lines_ready
    );

endinterface

// File: rtl/tetris_stats_bcd_digit_add.sv
// ----------------------------------------------------------------------------
// tetris_stats_bcd_digit_add
// Combinational single-digit BCD adder.
//   i_a, i_b  BCD digit operands
//   i_cin     carry in
//   o_s       BCD sum digit
//   o_cout    decimal carry out
// ----------------------------------------------------------------------------
module tetris_stats_bcd_digit_add
    import tetris_stats_pkg::*;
(
    input  logic [BCD_DIGIT_WIDTH-1:0] i_a,
    input  logic [BCD_DIGIT_WIDTH-1:0] i_b,
    input  logic                       i_cin,
    output logic [BCD_DIGIT_WIDTH-1:0] o_s,
    output logic                       o_cout
);

    logic [BCD_DIGIT_WIDTH:0] w_sum;

    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, i_b} + {{BCD_DIGIT_WIDTH{1'b0}}, i_cin};
        if (w_sum > 5'd9) begin
            // +6 skips the six unused binary codes; the wrap drops bit 4.
            o_s    = w_sum[BCD_DIGIT_WIDTH-1:0] + 4'd6;
            o_cout = 1'b1;
        end else begin
            o_s    = w_sum[BCD_DIGIT_WIDTH-1:0];
            o_cout = 1'b0;
        end
    end

endmodule

// File: rtl/tetris_stats.sv
// ----------------------------------------------------------------------------
// tetris_stats
// Score / lines / level writer for the on-screen text renderer. Line-clear
// events update private working copies digit-serially through one shared
// BCD digit adder; all three displayed counters change on a single edge.
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   new_game_i  synchronous clear, highest priority
//   lines_if    line-clear event handshake (slave side)
//   gd_score_o  score, BCD
//   gd_lines_o  total cleared lines, BCD
//   gd_level_o  current level, BCD
// ----------------------------------------------------------------------------
module tetris_stats
    import tetris_stats_pkg::*;
#(
    parameter int unsigned LEVEL_MAX = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          new_game_i,
    tetris_stats_if.slave lines_if,
    output bcd_num_t      gd_score_o,
    output bcd_num_t      gd_lines_o,
    output bcd_num_t      gd_level_o
);

    localparam int unsigned LVL_W = $clog2(LEVEL_MAX + 1);

    state_e                 r_state;
    bcd_num_t               r_score;
    bcd_num_t               r_lines;
    bcd_num_t               r_level;
    bcd_num_t               r_wk_score;
    bcd_num_t               r_wk_lines;
    logic [LVL_W-1:0]       r_level_bin;
    logic [LVL_W-1:0]       r_pass;
    logic [2:0]             r_n;
    logic [DIGIT_IDX_W-1:0] r_digit;
    logic                   r_carry;
    logic                   r_lvl_up;

    bcd_num_t                   w_pts;
    logic [BCD_DIGIT_WIDTH-1:0] w_a;
    logic [BCD_DIGIT_WIDTH-1:0] w_b;
    logic [BCD_DIGIT_WIDTH-1:0] w_s;
    logic                       w_cout;
    logic                       w_last_digit;

    assign w_pts        = points_for(r_n);
    assign w_last_digit = (r_digit == DIGIT_IDX_W'(NUMBER_LEN - 1));

    // Digit mux sharing the adder between the lines and score phases.
    always_comb begin
        w_a = r_wk_score[r_digit];
        w_b = w_pts[r_digit];
        if (r_state == StAddLines) begin
            w_a = r_wk_lines[r_digit];
            w_b = (r_digit == '0) ? {1'b0, r_n} : 4'd0;
        end
    end

    tetris_stats_bcd_digit_add u_digit_add (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_score     <= BCD_ZERO;
            r_lines     <= BCD_ZERO;
            r_level     <= BCD_ONE;
            r_level_bin <= LVL_W'(1);
            r_wk_score  <= BCD_ZERO;
            r_wk_lines  <= BCD_ZERO;
            r_pass      <= '0;
            r_n         <= 3'd0;
            r_digit     <= '0;
            r_carry     <= 1'b0;
            r_lvl_up    <= 1'b0;
        end else if (new_game_i) begin
            r_state     <= StIdle;
            r_score     <= BCD_ZERO;
            r_lines     <= BCD_ZERO;
            r_level     <= BCD_ONE;
            r_level_bin <= LVL_W'(1);
            r_wk_score  <= BCD_ZERO;
            r_wk_lines  <= BCD_ZERO;
            r_pass      <= '0;
            r_n         <= 3'd0;
            r_digit     <= '0;
            r_carry     <= 1'b0;
            r_lvl_up    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (lines_if.lines_valid) begin
                        r_wk_score <= r_score;
                        r_wk_lines <= r_lines;
                        r_n        <= lines_if.lines_cleared;
                        r_digit    <= '0;
                        r_pass     <= '0;
                        r_carry    <= 1'b0;
                        // Crossing a multiple of ten is visible from digit 0 alone.
                        r_lvl_up   <= is_legal(lines_if.lines_cleared) &&
                                      (({1'b0, r_lines[0]} +
                                        {2'b00, lines_if.lines_cleared}) >= 5'd10);
                        r_state    <= is_legal(lines_if.lines_cleared) ? StAddLines
                                                                       : StCommit;
                    end
                end
                StAddLines: begin
                    r_wk_lines[r_digit] <= w_s;
                    if (w_last_digit) begin
                        if (w_cout) begin
                            r_wk_lines <= BCD_MAX;
                        end
                        r_digit <= '0;
                        r_carry <= 1'b0;
                        r_state <= StAddScore;
                    end else begin
                        r_digit <= r_digit + DIGIT_IDX_W'(1);
                        r_carry <= w_cout;
                    end
                end
                StAddScore: begin
                    r_wk_score[r_digit] <= w_s;
                    if (w_last_digit) begin
                        r_digit <= '0;
                        r_carry <= 1'b0;
                        if (w_cout) begin
                            // Saturated: further passes cannot change the value.
                            r_wk_score <= BCD_MAX;
                            r_state    <= StCommit;
                        end else if (r_pass == r_level_bin - LVL_W'(1)) begin
                            r_state <= StCommit;
                        end else begin
                            r_pass <= r_pass + LVL_W'(1);
                        end
                    end else begin
                        r_digit <= r_digit + DIGIT_IDX_W'(1);
                        r_carry <= w_cout;
                    end
                end
                StCommit: begin
                    r_score <= r_wk_score;
                    r_lines <= r_wk_lines;
                    if (r_lvl_up && (r_level_bin < LVL_W'(LEVEL_MAX))) begin
                        r_level_bin <= r_level_bin + LVL_W'(1);
                        if (r_level[0] == 4'd9) begin
                            r_level[0] <= 4'd0;
                            r_level[1] <= r_level[1] + 4'd1;
                        end else begin
                            r_level[0] <= r_level[0] + 4'd1;
                        end
                    end
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign lines_if.lines_ready = (r_state == StIdle);
    assign gd_score_o           = r_score;
    assign gd_lines_o           = r_lines;
    assign gd_level_o           = r_level;

endmodule
